// File: rtl/id_ex_forward_stage.sv
// ID/EX register with operand forwarding, bubble insertion,
// PC/IF-ID load enables and stall-run supervision.
module id_ex_forward_stage #(
  parameter int unsigned DW        = 32,
  parameter int unsigned CW        = 8,
  parameter int unsigned MAX_STALL = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    ISA,
  input  logic [1:0]    ISB,
  input  logic [1:0]    ISC,
  input  logic          stall_pipeline,
  input  logic          flush,
  input  logic [DW-1:0] PA_ID,
  input  logic [DW-1:0] PB_ID,
  input  logic [DW-1:0] PC_ID,
  input  logic [DW-1:0] EX_result,
  input  logic [DW-1:0] MEM_result,
  input  logic [DW-1:0] WB_result,
  input  logic [CW-1:0] CTRL_ID,
  input  logic [3:0]    RW_ID,
  input  logic          enable_RF_ID,
  input  logic          enable_LD_ID,
  output logic [DW-1:0] PA_EX,
  output logic [DW-1:0] PB_EX,
  output logic [DW-1:0] PC_EX,
  output logic [CW-1:0] CTRL_EX,
  output logic [3:0]    RW_EX,
  output logic          enable_RF_EX,
  output logic          enable_LD_EX,
  output logic          LE_PC,
  output logic          LE_IF_ID,
  output logic [15:0]   stall_count,
  output logic          stall_error
);

  typedef enum logic {RUN, STALL} state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    run_len;
  logic [3:0]    run_len_nx;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] op_c;
  logic          bubble;
  logic          stall_hit;
  logic          run_over;

  function automatic logic [DW-1:0] fwd(
    input logic [1:0]    sel,
    input logic [DW-1:0] rf
  );
    unique case (sel)
      2'b00:   fwd = rf;
      2'b01:   fwd = EX_result;
      2'b10:   fwd = MEM_result;
      default: fwd = WB_result;
    endcase
  endfunction

  // Operand forwarding muxes and hazard qualifiers
  always_comb begin
    op_a      = fwd(ISA, PA_ID);
    op_b      = fwd(ISB, PB_ID);
    op_c      = fwd(ISC, PC_ID);
    bubble    = stall_pipeline | flush;
    stall_hit = stall_pipeline & ~flush;
    LE_PC     = ~stall_pipeline | flush;
    LE_IF_ID  = ~stall_pipeline | flush;
  end

  // Stall-run FSM next state; flush always returns to RUN
  always_comb begin
    state_nx   = state;
    run_len_nx = run_len;
    unique case (state)
      RUN: begin
        if (stall_hit) begin
          state_nx   = STALL;
          run_len_nx = 4'd1;
        end
      end
      default: begin
        if (stall_hit) begin
          if (run_len != 4'hF)
            run_len_nx = run_len + 4'd1;
        end else begin
          state_nx   = RUN;
          run_len_nx = 4'd0;
        end
      end
    endcase
    run_over = stall_hit && (32'(run_len_nx) > MAX_STALL);
  end

  // ID/EX register; bubble zeroes control, operands still load
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      PA_EX        <= '0;
      PB_EX        <= '0;
      PC_EX        <= '0;
      CTRL_EX      <= '0;
      RW_EX        <= '0;
      enable_RF_EX <= 1'b0;
      enable_LD_EX <= 1'b0;
    end else begin
      PA_EX <= op_a;
      PB_EX <= op_b;
      PC_EX <= op_c;
      if (bubble) begin
        CTRL_EX      <= '0;
        RW_EX        <= '0;
        enable_RF_EX <= 1'b0;
        enable_LD_EX <= 1'b0;
      end else begin
        CTRL_EX      <= CTRL_ID;
        RW_EX        <= RW_ID;
        enable_RF_EX <= enable_RF_ID;
        enable_LD_EX <= enable_LD_ID;
      end
    end
  end

  // FSM state, saturating counters and sticky stuck-stall flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= RUN;
      run_len     <= '0;
      stall_count <= '0;
      stall_error <= 1'b0;
    end else begin
      state   <= state_nx;
      run_len <= run_len_nx;
      if (stall_hit && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if (run_over)
        stall_error <= 1'b1;
    end
  end

endmodule
